// File: rtl/psram_async_responder_pkg.sv
// Shared definitions for the asynchronous-mode cellular RAM responder:
// one-hot state encodings, default access timings, address width and the
// helper that converts a cycle count into a wait-timer load value.
package psram_async_responder_pkg;

   // External cellular RAM word address width
   localparam int unsigned RAM_ADDR_W = 23;

   // Width of the shared wait timer (covers 1..15 cycles)
   localparam int unsigned TIMER_W = 4;

   // Default timings in clk cycles at 100 MHz
   localparam int unsigned WR_CYCLES_DEF = 7;
   localparam int unsigned RD_CYCLES_DEF = 8;

   // One-hot access sequencer states
   typedef enum logic [5:0] {
      ST_IDLE     = 6'b000001,
      ST_SETUP    = 6'b000010,
      ST_WR_PULSE = 6'b000100,
      ST_WR_HOLD  = 6'b001000,
      ST_RD_WAIT  = 6'b010000,
      ST_RECOV    = 6'b100000
   } state_t;

   // The timer is loaded with N-1 so that its done flag is seen in the
   // N-th cycle of the timed state.
   function automatic logic [TIMER_W-1:0] timer_load(input int unsigned cycles);
      return TIMER_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/psram_wait_timer.sv
// 4-bit load/decrement counter timing the write pulse and the read wait.
// done is high whenever the count has reached zero.
module psram_wait_timer
   import psram_async_responder_pkg::*;
(
   input  logic               clk,
   input  logic               sys_rst_n,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               dec,
   output logic               done
);

   logic [TIMER_W-1:0] count_reg;

   // Load has priority; decrement stops at zero so done stays asserted
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign done = (count_reg == '0);

endmodule

// File: rtl/psram_async_responder.sv
// Memory-side responder: turns single-word mem_* requests into one
// asynchronous-mode cellular RAM access each. Every RAM strobe comes
// straight from a flop so the pads never see combinational glitches.
// The pad tristate buffer lives in the top-level wrapper.
module psram_async_responder
   import psram_async_responder_pkg::*;
#(
   parameter int unsigned WR_CYCLES = WR_CYCLES_DEF,
   parameter int unsigned RD_CYCLES = RD_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   // request side
   input  logic                  mem_we,
   input  logic                  mem_re,
   input  logic [31:0]           mem_addr,
   input  logic [15:0]           mem_wdata,
   output logic                  mem_rdy,
   output logic [15:0]           mem_rdata,
   output logic                  mem_rvalid,
   output logic [7:0]            drop_cnt,
   // cellular RAM side
   output logic [RAM_ADDR_W-1:0] ram_addr,
   output logic [15:0]           ram_dq_o,
   output logic                  ram_dq_oe,
   input  logic [15:0]           ram_dq_i,
   output logic                  ram_ce_n,
   output logic                  ram_oe_n,
   output logic                  ram_we_n,
   output logic                  ram_lb_n,
   output logic                  ram_ub_n,
   output logic                  ram_adv_n,
   output logic                  ram_clk,
   output logic                  ram_cre
);

   state_t               state_reg;
   logic                 op_write_reg;

   logic                 req;
   logic                 accept;
   logic                 timer_load_en;
   logic                 timer_dec;
   logic                 timer_done;
   logic [TIMER_W-1:0]   timer_val;

   // Upper address bits are outside the RAM and intentionally ignored
   logic                 unused_addr_bits;
   assign unused_addr_bits = ^mem_addr[31:RAM_ADDR_W];

   // Async mode: no burst clock, no address-valid strobe, no config access
   assign ram_adv_n = 1'b0;
   assign ram_clk   = 1'b0;
   assign ram_cre   = 1'b0;

   // mem_rdy is high exactly in IDLE, so it doubles as the accept qualifier
   assign req    = mem_we | mem_re;
   assign accept = req & mem_rdy;

   // Timer is armed during SETUP with the length of the upcoming phase
   assign timer_load_en = (state_reg == ST_SETUP);
   assign timer_val     = op_write_reg ? timer_load(WR_CYCLES) : timer_load(RD_CYCLES);
   assign timer_dec     = (state_reg == ST_WR_PULSE) || (state_reg == ST_RD_WAIT);

   psram_wait_timer u_wait_timer (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .load      (timer_load_en),
      .load_val  (timer_val),
      .dec       (timer_dec),
      .done      (timer_done)
   );

   // Access sequencer; all outputs are registered and change with the state
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg    <= ST_IDLE;
         op_write_reg <= 1'b0;
         mem_rdy      <= 1'b1;
         mem_rdata    <= '0;
         mem_rvalid   <= 1'b0;
         ram_addr     <= '0;
         ram_dq_o     <= '0;
         ram_dq_oe    <= 1'b0;
         ram_ce_n     <= 1'b1;
         ram_oe_n     <= 1'b1;
         ram_we_n     <= 1'b1;
         ram_lb_n     <= 1'b1;
         ram_ub_n     <= 1'b1;
      end else begin
         mem_rvalid <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  // A simultaneous write and read resolves to the write
                  op_write_reg <= mem_we;
                  ram_addr     <= mem_addr[RAM_ADDR_W-1:0];
                  if (mem_we) begin
                     ram_dq_o  <= mem_wdata;
                     ram_dq_oe <= 1'b1;
                  end
                  ram_ce_n  <= 1'b0;
                  ram_lb_n  <= 1'b0;
                  ram_ub_n  <= 1'b0;
                  mem_rdy   <= 1'b0;
                  state_reg <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (op_write_reg) begin
                  ram_we_n  <= 1'b0;
                  state_reg <= ST_WR_PULSE;
               end else begin
                  ram_oe_n  <= 1'b0;
                  state_reg <= ST_RD_WAIT;
               end
            end

            ST_WR_PULSE: begin
               if (timer_done) begin
                  ram_we_n  <= 1'b1;
                  state_reg <= ST_WR_HOLD;
               end
            end

            ST_WR_HOLD: begin
               // Data and chip enable were held one cycle past we_n rising
               ram_ce_n  <= 1'b1;
               ram_lb_n  <= 1'b1;
               ram_ub_n  <= 1'b1;
               ram_dq_oe <= 1'b0;
               state_reg <= ST_RECOV;
            end

            ST_RD_WAIT: begin
               if (timer_done) begin
                  mem_rdata  <= ram_dq_i;
                  mem_rvalid <= 1'b1;
                  ram_oe_n   <= 1'b1;
                  ram_ce_n   <= 1'b1;
                  ram_lb_n   <= 1'b1;
                  ram_ub_n   <= 1'b1;
                  state_reg  <= ST_RECOV;
               end
            end

            ST_RECOV: begin
               mem_rdy   <= 1'b1;
               state_reg <= ST_IDLE;
            end

            default: begin
               // Illegal encoding: park the bus safely and return to IDLE
               ram_ce_n  <= 1'b1;
               ram_oe_n  <= 1'b1;
               ram_we_n  <= 1'b1;
               ram_lb_n  <= 1'b1;
               ram_ub_n  <= 1'b1;
               ram_dq_oe <= 1'b0;
               mem_rdy   <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   // Count requests that arrive while busy, saturating at all-ones
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         drop_cnt <= '0;
      end else if (req && !mem_rdy && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_psram_async_responder.sv
// Self-checking bench for psram_async_responder: a vector table of requests
// with expected RAM-side behaviour, a read-data scoreboard, a small RAM
// model, and hand-written sequences for drops, saturation and reset.
`timescale 1ns/1ps
module tb_psram_async_responder;

   localparam int WR     = 7;
   localparam int RD     = 8;
   localparam int ACC    = 11;   // accept -> mem_rdy high again, both ops
   localparam int RV_AT  = 10;   // accept -> mem_rvalid cycle for reads

   logic        clk = 1'b0;
   logic        sys_rst_n = 1'b1;
   logic        mem_we = 1'b0;
   logic        mem_re = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [15:0] mem_wdata = '0;
   logic        mem_rdy;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic [7:0]  drop_cnt;
   logic [22:0] ram_addr;
   logic [15:0] ram_dq_o;
   logic        ram_dq_oe;
   logic [15:0] ram_dq_i;
   logic        ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n;
   logic        ram_adv_n, ram_clk, ram_cre;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   psram_async_responder #(.WR_CYCLES(WR), .RD_CYCLES(RD)) dut (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdy    (mem_rdy),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .drop_cnt   (drop_cnt),
      .ram_addr   (ram_addr),
      .ram_dq_o   (ram_dq_o),
      .ram_dq_oe  (ram_dq_oe),
      .ram_dq_i   (ram_dq_i),
      .ram_ce_n   (ram_ce_n),
      .ram_oe_n   (ram_oe_n),
      .ram_we_n   (ram_we_n),
      .ram_lb_n   (ram_lb_n),
      .ram_ub_n   (ram_ub_n),
      .ram_adv_n  (ram_adv_n),
      .ram_clk    (ram_clk),
      .ram_cre    (ram_cre)
   );

   // RAM model: 256 words indexed by the low address byte, plus a backdoor
   logic [15:0] ram_model [256];
   logic        bd_en = 1'b0;
   logic [7:0]  bd_idx = '0;
   logic [15:0] bd_val = '0;

   always @(posedge clk) begin
      if (bd_en)
         ram_model[bd_idx] <= bd_val;
      else if (!ram_ce_n && !ram_we_n)
         ram_model[ram_addr[7:0]] <= ram_dq_o;
   end

   assign ram_dq_i = (!ram_ce_n && !ram_oe_n) ? ram_model[ram_addr[7:0]] : 16'hBEEF;

   // Expected contents as seen by the requester, and the read scoreboard
   logic [15:0] shadow [logic [22:0]];
   logic [15:0] exp_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Bus monitor: write pulse count, oe/dq_oe overlap, read data scoreboard
   int   we_pulses = 0;
   int   conflicts = 0;
   logic prev_we_n = 1'b1;

   always @(negedge clk) begin
      if (prev_we_n && !ram_we_n) we_pulses++;
      prev_we_n = ram_we_n;
      if (ram_dq_oe && !ram_oe_n) conflicts++;
      if (mem_rvalid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected: got rvalid with rdata=0x%0h, required no rvalid", mem_rdata);
         end else begin
            check("rdata", {16'h0, mem_rdata}, {16'h0, exp_q.pop_front()});
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [15:0] wdata;
      logic [22:0] exp_addr;
      logic        exp_write;
      logic        exp_rvalid;
   } vec_t;

   // Issue one request and verify the complete access against the vector
   task automatic run_vec(input vec_t v, input string tag);
      int g = 0;
      int k = 1;
      int we_low = 0, we_first = 0, oe_low = 0, oe_first = 0;
      int rv_k = 0, bad = 0, oe_seen = 0;
      while (!mem_rdy && g < 50) begin
         step();
         g++;
      end
      check({tag, "_rdy_before"}, {31'h0, mem_rdy}, 32'h1);
      if (v.exp_write) shadow[v.exp_addr] = v.wdata;
      else exp_q.push_back(shadow[v.exp_addr]);
      mem_we    = v.we;
      mem_re    = v.re;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
      @(posedge clk);
      #1;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = $urandom;
      mem_wdata = 16'($urandom);
      while (!mem_rdy && k < 40) begin
         if (!ram_we_n) begin
            we_low++;
            if (we_first == 0) we_first = k;
            if (ram_addr !== v.exp_addr || ram_dq_o !== v.wdata || ram_dq_oe !== 1'b1 ||
                ram_ce_n !== 1'b0 || ram_lb_n !== 1'b0 || ram_ub_n !== 1'b0) bad++;
         end
         if (!ram_oe_n) begin
            oe_low++;
            if (oe_first == 0) oe_first = k;
            if (ram_addr !== v.exp_addr || ram_ce_n !== 1'b0 || ram_lb_n !== 1'b0 ||
                ram_ub_n !== 1'b0) bad++;
         end
         if (ram_dq_oe) oe_seen = 1;
         if (mem_rvalid) rv_k = k;
         step();
         k++;
      end
      check({tag, "_rdy_latency"}, k, ACC);
      check({tag, "_bus_drive"}, bad, 0);
      if (v.exp_write) begin
         check({tag, "_we_len"}, we_low, WR);
         check({tag, "_we_first"}, we_first, 2);
         check({tag, "_oe_len"}, oe_low, 0);
      end else begin
         check({tag, "_oe_len"}, oe_low, RD);
         check({tag, "_oe_first"}, oe_first, 2);
         check({tag, "_we_len"}, we_low, 0);
         check({tag, "_dq_oe_in_read"}, oe_seen, 0);
      end
      check({tag, "_rvalid_at"}, rv_k, v.exp_rvalid ? RV_AT : 0);
      $display("txn %s: we=%0b re=%0b addr=0x%08h wdata=0x%04h -> ram_addr=0x%06h rdy_after=%0d rvalid_at=%0d",
               tag, v.we, v.re, v.addr, v.wdata, v.exp_addr, k, rv_k);
   endtask

   // Pulse sys_rst_n low in the 4th cycle of the timed phase of an access
   task automatic reset_mid_access(input logic is_write, input string tag);
      int k = 1;
      while (!mem_rdy) step();
      mem_we    = is_write;
      mem_re    = !is_write;
      mem_addr  = 32'h7;
      mem_wdata = 16'h7777;
      @(posedge clk);
      #1;
      mem_we = 1'b0;
      mem_re = 1'b0;
      while (k < 5) begin
         step();
         k++;
      end
      if (is_write) check({tag, "_we_low_pre"}, {31'h0, ram_we_n}, 32'h0);
      else          check({tag, "_oe_low_pre"}, {31'h0, ram_oe_n}, 32'h0);
      #2;
      sys_rst_n = 1'b0;
      #1;
      check({tag, "_we_n"},  {31'h0, ram_we_n},  32'h1);
      check({tag, "_oe_n"},  {31'h0, ram_oe_n},  32'h1);
      check({tag, "_ce_n"},  {31'h0, ram_ce_n},  32'h1);
      check({tag, "_dq_oe"}, {31'h0, ram_dq_oe}, 32'h0);
      check({tag, "_rdy"},   {31'h0, mem_rdy},   32'h1);
      check({tag, "_drop"},  {24'h0, drop_cnt},  32'h0);
      #1;
      sys_rst_n = 1'b1;
      step();
      check({tag, "_rdy_after"}, {31'h0, mem_rdy}, 32'h1);
      $display("txn %s: reset applied in access cycle 5", tag);
   endtask

   vec_t vecs [8];
   vec_t v3c;
   int   p0, k, sent, guard, rv_seen;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h0000_0005, 16'h00A5, 23'h000005, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 32'h0000_0005, 16'h0000, 23'h000005, 1'b0, 1'b1};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0012, 16'h1234, 23'h000012, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 16'h5A5A, 23'h7FFFFF, 1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_0012, 16'h0000, 23'h000012, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 16'h0000, 23'h7FFFFF, 1'b0, 1'b1};
      vecs[6] = '{1'b1, 1'b0, 32'hABAB_CDEF, 16'hC3C3, 23'h2BCDEF, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 32'h002B_CDEF, 16'h0000, 23'h2BCDEF, 1'b0, 1'b1};
      v3c     = '{1'b0, 1'b1, 32'h0000_0005, 16'h0000, 23'h000005, 1'b0, 1'b1};

      // Reset state
      #1;
      sys_rst_n = 1'b0;
      #2;
      check("rst_rdy",    {31'h0, mem_rdy},    32'h1);
      check("rst_rvalid", {31'h0, mem_rvalid}, 32'h0);
      check("rst_rdata",  {16'h0, mem_rdata},  32'h0);
      check("rst_drop",   {24'h0, drop_cnt},   32'h0);
      check("rst_addr",   {9'h0, ram_addr},    32'h0);
      check("rst_dq_o",   {16'h0, ram_dq_o},   32'h0);
      check("rst_dq_oe",  {31'h0, ram_dq_oe},  32'h0);
      check("rst_strobes", {27'h0, ram_ce_n, ram_oe_n, ram_we_n, ram_lb_n, ram_ub_n}, 32'h1F);
      check("rst_async_mode", {29'h0, ram_adv_n, ram_clk, ram_cre}, 32'h0);
      repeat (2) @(posedge clk);
      #3;
      sys_rst_n = 1'b1;
      step();

      // Table-driven accesses
      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Read with the RAM model returning 0x3C00
      shadow[23'h5] = 16'h3C00;
      bd_en  = 1'b1;
      bd_idx = 8'h05;
      bd_val = 16'h3C00;
      step();
      bd_en = 1'b0;
      run_vec(v3c, "read3c00");

      // Three write requests while busy: all dropped, one RAM write only
      mem_we    = 1'b1;
      mem_addr  = 32'h40;
      mem_wdata = 16'h4040;
      shadow[23'h40] = 16'h4040;
      p0 = we_pulses;
      @(posedge clk);
      #1;
      mem_we = 1'b0;
      k = 1;
      while (!mem_rdy && k < 40) begin
         mem_we = (k == 3 || k == 5 || k == 7);
         step();
         k++;
      end
      mem_we = 1'b0;
      check("drop_three", {24'h0, drop_cnt}, 32'h3);
      check("drop_one_pulse", we_pulses - p0, 1);
      $display("txn drop3: drop_cnt=%0d we_pulses=%0d", drop_cnt, we_pulses - p0);

      // 300 more busy requests: drop_cnt saturates at 255
      sent  = 0;
      guard = 0;
      while (sent < 300 && guard < 5000) begin
         if (mem_rdy) begin
            mem_we = 1'b1;
            mem_re = 1'b0;
         end else begin
            mem_we = 1'b0;
            mem_re = 1'b1;
            sent++;
         end
         step();
         guard++;
         if (sent == 97 && !mem_we) check("drop_mid", {24'h0, drop_cnt}, 32'd100);
      end
      mem_we = 1'b0;
      mem_re = 1'b0;
      check("drop_sent", sent, 300);
      guard = 0;
      while (!mem_rdy && guard < 50) begin
         step();
         guard++;
      end
      check("drop_sat", {24'h0, drop_cnt}, 32'd255);
      $display("txn drop300: drop_cnt=%0d", drop_cnt);

      // Reset in the middle of a write, then of a read (no rvalid may follow)
      reset_mid_access(1'b1, "rst_wr");
      reset_mid_access(1'b0, "rst_rd");
      rv_seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (mem_rvalid) rv_seen++;
         step();
      end
      check("rst_rd_no_rvalid", rv_seen, 0);

      // Recovery: normal read after the aborted accesses
      run_vec(v3c, "read_after_rst");

      check("oe_dq_conflicts", conflicts, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/psram_async_responder.md
# psram_async_responder

Memory-side responder for the board RAM test path. It accepts single-word write and read requests on the `mem_*` handshake that the button/switch control logic drives. It executes each request as one asynchronous-mode access on the external cellular RAM, and holds `mem_rdy` low for the whole access. It sits between the control logic and the top-level pad/tristate wrapper.

## Interface
- `WR_CYCLES`, default 7: clk cycles `ram_we_n` is held low; legal range 1–15.
- `RD_CYCLES`, default 8: clk cycles from `ram_oe_n` low to data sample; legal range 1–15.
- `clk` input, 1 bit: system clock (100 MHz nominal).
- `sys_rst_n` input, 1 bit: asynchronous, active-low reset.
- `mem_we` input, 1 bit: write request pulse.
- `mem_re` input, 1 bit: read request pulse.
- `mem_addr` input, 32 bits: word address; only bits [22:0] are used.
- `mem_wdata` input, 16 bits: write data.
- `mem_rdy` output, 1 bit: high = idle, request will be accepted.
- `mem_rdata` output, 16 bits: last read data; held until the next read completes.
- `mem_rvalid` output, 1 bit: one-cycle pulse, `mem_rdata` updated.
- `drop_cnt` output, 8 bits: count of requests ignored while busy; saturates at 255.
- `ram_addr` output, 23 bits: external address.
- `ram_dq_o` output, 16 bits: write data to pads.
- `ram_dq_oe` output, 1 bit: pad output enable.
- `ram_dq_i` input, 16 bits: read data from pads.
- `ram_ce_n`, `ram_oe_n`, `ram_we_n`, `ram_lb_n`, `ram_ub_n` outputs, 1 bit each: active-low strobes.
- `ram_adv_n`, `ram_clk`, `ram_cre` outputs, 1 bit each: constant 0, selecting async mode.

## Operation
- States: IDLE, SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RECOV.
- Reset values:
  - `mem_rdy`=1, `mem_rvalid`=0, `mem_rdata`=0, `drop_cnt`=0, `ram_addr`=0, `ram_dq_o`=0.
  - `ram_dq_oe`=0, all strobes high (`ram_lb_n`/`ram_ub_n` = 1), state IDLE.
- IDLE: `mem_rdy`=1. Request accepted on an edge where `mem_rdy` is high and `mem_we` or `mem_re` is high.
  - On accept, latch `mem_addr[22:0]`, `mem_wdata` and the op, then go to SETUP.
  - If `mem_we` and `mem_re` are high together, it is a write; the read is discarded and not counted.
- SETUP (1 cycle): `ram_addr` valid, `ram_ce_n`=0, `ram_lb_n`=`ram_ub_n`=0.
  - Write: also `ram_dq_oe`=1 and `ram_dq_o`=wdata.
  - Next state: WR_PULSE for a write, RD_WAIT for a read.
- WR_PULSE: `ram_we_n`=0 for exactly WR_CYCLES cycles, then WR_HOLD.
- WR_HOLD (1 cycle): `ram_we_n`=1; ce, addr and data are still driven; then RECOV.
- RD_WAIT: `ram_oe_n`=0 for RD_CYCLES cycles.
  - `ram_dq_i` is registered into `mem_rdata` on the last edge.
  - `mem_rvalid`=1 during the following RECOV cycle; then RECOV.
- RECOV (1 cycle): all strobes high, `ram_dq_oe`=0; then IDLE.
- `ram_dq_oe` and `ram_oe_n`=0 are never active in the same cycle.
- Any `mem_we`/`mem_re` while `mem_rdy`=0 is ignored and `drop_cnt` increments (saturating).
- All external strobes come straight from registers, so there are no glitches.

## Timing
- Accept edge = cycle 0 (state IDLE); `mem_rdy` falls in cycle 1.
- Write: SETUP in cycle 1; `ram_we_n` low in cycles 2..WR_CYCLES+1; WR_HOLD in WR_CYCLES+2; RECOV in WR_CYCLES+3.
  - `mem_rdy` is high again in cycle WR_CYCLES+4 (11 at default).
- Read: `ram_oe_n` low in cycles 2..RD_CYCLES+1; `mem_rvalid` in cycle RD_CYCLES+2 (10).
  - `mem_rdy` is high in cycle RD_CYCLES+3 (11).
- Back-to-back: a request arriving in the first IDLE cycle is accepted; there are no dead cycles beyond RECOV.
- Reset mid-access:
  - Strobes go high and `ram_dq_oe` goes 0 asynchronously.
  - The access is abandoned and `mem_rvalid` is not produced.
- Address wraps naturally at 23 bits; upper `mem_addr` bits are don't-care.

## Structure
- Shared package holds:
  - the one-hot state encodings;
  - the default WR_CYCLES/RD_CYCLES values;
  - the RAM address width constant (23).
- One sub-module is natural: `psram_wait_timer`, a 4-bit load/decrement counter with a `done` flag, used for both WR_PULSE and RD_WAIT.
- Pad tristate stays in the top level, not here.

## Test plan
- Reset → `mem_rdy`=1, `ram_ce_n`=1, `ram_dq_oe`=0, `drop_cnt`=0, `ram_adv_n`=`ram_clk`=`ram_cre`=0.
- Write pulse, addr=0x5, wdata=0x00A5 → `ram_we_n` low for exactly 7 cycles with `ram_addr`=5, `ram_dq_o`=0x00A5; `mem_rdy` is high 11 cycles after accept.
- Read, addr=0x5, with the model returning 0x3C00 → `mem_rvalid` one cycle at accept+10, `mem_rdata`=0x3C00; `ram_dq_oe` stays 0 throughout.
- `mem_we` pulsed 3 times during a busy write → `drop_cnt`=3 and only one `ram_we_n` pulse; then 300 busy requests → `drop_cnt`=255.
- Simultaneous `mem_we`+`mem_re`, addr=0xFFFFFFFF → write performed at `ram_addr`=0x7FFFFF, no `mem_rvalid`.
- `sys_rst_n` asserted in cycle 4 of WR_PULSE → `ram_we_n`/`ram_ce_n` high and `ram_dq_oe`=0 with no clock edge; `mem_rdy`=1 after release.
